// File: rtl/uart_io_sched.sv
// rtl/uart_io_sched.sv - byte scheduler between core TX/RX FIFOs and the single-op UART bridge
// Optional read-ahead of RX bytes enabled by defining UART_RX_PREFETCH_EN.
module uart_io_sched #(
    parameter int TX_AW = 3,
    parameter int RX_AW = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [TX_AW:0]   tx_level,
    output logic [RX_AW:0]   rx_level,
    output logic             busy,
    output logic [7:0]       br_output,
    output logic             br_outready,
    input  logic             br_outvalid,
    output logic             br_inready,
    input  logic [7:0]       br_input,
    input  logic             br_invalid
);

    localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(1 << TX_AW);
    localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(1 << RX_AW);

    typedef enum logic [1:0] {S_IDLE, S_TX, S_RX} state_t;
    state_t state;

    logic [7:0]       tx_mem [1 << TX_AW];
    logic [7:0]       rx_mem [1 << RX_AW];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;

    logic tx_push, tx_pop, rx_push, rx_pop, rd_ok;

    assign tx_ready = (tx_level != TX_FULL);
    assign rx_valid = (rx_level != '0);
    assign rx_data  = rx_mem[rx_rd_ptr];

    assign tx_push = tx_valid & tx_ready;
    assign tx_pop  = (state == S_TX) & br_outvalid & (tx_level != '0);
    assign rx_push = (state == S_RX) & br_invalid & (rx_level != RX_FULL);
    assign rx_pop  = rx_valid & rx_ready;

`ifdef UART_RX_PREFETCH_EN
    assign rd_ok = (rx_level != RX_FULL);
`else
    assign rd_ok = rx_ready & (rx_level == '0);
`endif

    // Requests drop in the done cycle so the bridge never sees a stale request.
    assign busy        = (state != S_IDLE);
    assign br_outready = (state == S_TX) & ~br_outvalid;
    assign br_inready  = (state == S_RX) & ~br_invalid;
    assign br_output   = (state == S_TX) ? tx_mem[tx_rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
        if (rx_push) rx_mem[rx_wr_ptr] <= br_input;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_push && !tx_pop)      tx_level <= tx_level + 1'b1;
            else if (!tx_push && tx_pop) tx_level <= tx_level - 1'b1;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_push && !rx_pop)      rx_level <= rx_level + 1'b1;
            else if (!rx_push && rx_pop) rx_level <= rx_level - 1'b1;
        end
    end

    // Every op returns through S_IDLE, which guarantees a low-request gap cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_level != '0) state <= S_TX;
                    else if (rd_ok)     state <= S_RX;
                end
                S_TX:    if (br_outvalid) state <= S_IDLE;
                S_RX:    if (br_invalid)  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io_sched.sv
// tb/tb_uart_io_sched.sv - directed self-checking bench for uart_io_sched
module tb_uart_io_sched;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [3:0] tx_level;
    logic [3:0] rx_level;
    logic       busy;
    logic [7:0] br_output;
    logic       br_outready;
    logic       br_outvalid = 1'b0;
    logic       br_inready;
    logic [7:0] br_input = 8'h00;
    logic       br_invalid = 1'b0;

    int errors = 0;
    int checks = 0;

    uart_io_sched #(.TX_AW(3), .RX_AW(3)) dut (
        .clk(clk), .rstn(rstn),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level), .busy(busy),
        .br_output(br_output), .br_outready(br_outready), .br_outvalid(br_outvalid),
        .br_inready(br_inready), .br_input(br_input), .br_invalid(br_invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic ack_tx();
        br_outvalid = 1'b1;
        #1;
        chk("outready_done_cycle", {15'd0, br_outready}, 16'd0);
        tick();
        br_outvalid = 1'b0;
        #1;
        chk("outready_after_done", {15'd0, br_outready}, 16'd0);
    endtask

    task automatic wait_inready();
        for (int i = 0; i < 10; i++) begin
            if (br_inready) break;
            tick();
        end
        chk("inready_wait", {15'd0, br_inready}, 16'd1);
    endtask

    initial begin
        #1;
        chk("rst_tx_ready", {15'd0, tx_ready}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_req", {14'd0, br_outready, br_inready}, 16'd0);
        chk("rst_output", {8'd0, br_output}, 16'd0);
        chk("rst_levels", {8'd0, tx_level, rx_level}, 16'd0);
        tick();
        rstn = 1'b1;
        tick();

`ifndef UART_RX_PREFETCH_EN
        // Test 1: reset while a write request is outstanding
        push_tx(8'h41);
        tick();
        chk("t1_outready", {15'd0, br_outready}, 16'd1);
        chk("t1_output", {8'd0, br_output}, 16'h41);
        rstn = 1'b0;
        #1;
        chk("t1_rst_outready", {15'd0, br_outready}, 16'd0);
        chk("t1_rst_level", {12'd0, tx_level}, 16'd0);
        chk("t1_rst_flags", {13'd0, rx_valid, tx_ready, busy}, 16'b010);
        tick();
        rstn = 1'b1;
        tick();

        // Test 2: two back-to-back bytes, each acked after 5 cycles
        tx_data = 8'h41; tx_valid = 1'b1; tick();
        tx_data = 8'h42; tick();
        tx_valid = 1'b0;
        chk("t2_level2", {12'd0, tx_level}, 16'd2);
        for (int k = 0; k < 2; k++) begin
            chk("t2_outready", {15'd0, br_outready}, 16'd1);
            for (int c = 0; c < 4; c++) tick();
            chk("t2_output_held", {8'd0, br_output}, k == 0 ? 16'h41 : 16'h42);
            ack_tx();
            chk("t2_idle_busy", {15'd0, busy}, 16'd0);
            tick();
        end
        chk("t2_level0", {12'd0, tx_level}, 16'd0);
        chk("t2_busy_end", {15'd0, busy}, 16'd0);

        // Test 3: bridge stalled, 9 pushes, 9th dropped
        for (int i = 0; i < 9; i++) begin
            push_tx(8'(i));
            if (i == 7) chk("t3_full_after8", {15'd0, tx_ready}, 16'd0);
        end
        chk("t3_level8", {12'd0, tx_level}, 16'd8);
        chk("t3_head", {8'd0, br_output}, 16'h00);
        ack_tx();
        chk("t3_ready_after_pop", {15'd0, tx_ready}, 16'd1);
        chk("t3_level7", {12'd0, tx_level}, 16'd7);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t3_drain_byte", {8'd0, br_output}, 16'(i));
            ack_tx();
        end
        tick();
        chk("t3_drained", {12'd0, tx_level}, 16'd0);
        chk("t3_no_dup_0x08", {15'd0, busy}, 16'd0);

        // Test 4: core waiting on empty RX triggers one read
        rx_ready = 1'b1;
        tick();
        chk("t4_inready", {15'd0, br_inready}, 16'd1);
        tick();
        chk("t4_excl", {15'd0, br_outready}, 16'd0);
        br_input = 8'h5A; br_invalid = 1'b1;
        #1;
        chk("t4_inready_done", {15'd0, br_inready}, 16'd0);
        tick();
        br_invalid = 1'b0;
        #1;
        chk("t4_rx_valid", {15'd0, rx_valid}, 16'd1);
        chk("t4_rx_data", {8'd0, rx_data}, 16'h5A);
        tick();
        rx_ready = 1'b0;
        #1;
        chk("t4_popped", {12'd0, rx_level}, 16'd0);
        tick();
        tick();
        chk("t4_no_reissue", {14'd0, br_inready, busy}, 16'd0);

        // Test 6: stray done pulses while idle
        br_outvalid = 1'b1; br_invalid = 1'b1; br_input = 8'h77;
        tick();
        br_outvalid = 1'b0; br_invalid = 1'b0;
        #1;
        chk("t6_busy", {15'd0, busy}, 16'd0);
        chk("t6_levels", {8'd0, tx_level, rx_level}, 16'd0);
        tick();
        chk("t6_still_idle", {15'd0, busy}, 16'd0);
`else
        // Test 5: read-ahead fills RX while core is not consuming
        for (int i = 0; i < 8; i++) begin
            wait_inready();
            chk("t5_excl", {15'd0, br_outready}, 16'd0);
            br_input = 8'(8'h10 + i); br_invalid = 1'b1;
            tick();
            br_invalid = 1'b0;
        end
        tick(); tick();
        chk("t5_rx_full", {12'd0, rx_level}, 16'd8);
        chk("t5_no_read", {15'd0, br_inready}, 16'd0);
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t5_rx_byte", {8'd0, rx_data}, 16'(8'h10 + i));
            tick();
        end
        rx_ready = 1'b0;
        wait_inready();
        push_tx(8'hC3);
        tick();
        chk("t5_tx_waits", {14'd0, br_outready, br_inready}, 16'b01);
        br_input = 8'h99; br_invalid = 1'b1;
        tick();
        br_invalid = 1'b0;
        #1;
        chk("t5_gap", {14'd0, br_outready, br_inready}, 16'd0);
        tick();
        chk("t5_tx_start", {15'd0, br_outready}, 16'd1);
        chk("t5_tx_byte", {8'd0, br_output}, 16'hC3);
        chk("t5_rx_level", {12'd0, rx_level}, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
